// File: rtl/multi_delay_gen.sv
// multi_delay_gen: multi-channel programmable delay generator.
// One start pulse drives each channel to its init level, then to its final
// level after a per-channel cycle delay; a done pulse marks the longest delay.
// Optional feature: define DELAY_GEN_RETRIGGER_EN to let start_i restart a
// running sequence (restart wins over completion on the same edge).
module multi_delay_gen #(
    parameter int unsigned          CHANNELS = 4,
    parameter int unsigned          CNT_W    = 16,
    parameter logic [CHANNELS-1:0]  OUT_RST  = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [CHANNELS*CNT_W-1:0] delay_i,
    input  logic [CHANNELS-1:0]       init_i,
    input  logic [CHANNELS-1:0]       level_i,
    output logic [CHANNELS-1:0]       out_o,
    output logic                      busy_o,
    output logic                      done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic [CNT_W-1:0]           w_cnt_inc;
    logic [CHANNELS*CNT_W-1:0]  r_delay;
    logic [CHANNELS*CNT_W-1:0]  w_delay_nxt;
    logic [CHANNELS-1:0]        r_level;
    logic [CHANNELS-1:0]        w_level_nxt;
    logic [CNT_W-1:0]           r_dmax;
    logic [CNT_W-1:0]           w_dmax_nxt;
    logic [CNT_W-1:0]           w_dmax_in;
    logic [CHANNELS-1:0]        r_out;
    logic [CHANNELS-1:0]        w_out_nxt;
    logic                       r_busy;
    logic                       w_busy_nxt;
    logic                       r_done;
    logic                       w_done_nxt;
    logic                       w_accept;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef DELAY_GEN_RETRIGGER_EN
    assign w_accept = start_i;
`else
    assign w_accept = start_i && (r_state == IDLE);
`endif

    // Longest requested delay among the incoming channel delays.
    always_comb begin
        w_dmax_in = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (delay_i[i*CNT_W +: CNT_W] > w_dmax_in) begin
                w_dmax_in = delay_i[i*CNT_W +: CNT_W];
            end
        end
    end

    // Next-state and next-output logic: accept/restart, per-channel firing, completion.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_delay_nxt = r_delay;
        w_level_nxt = r_level;
        w_dmax_nxt  = r_dmax;
        w_out_nxt   = r_out;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        if (w_accept) begin
            w_delay_nxt = delay_i;
            w_level_nxt = level_i;
            w_cnt_nxt   = '0;
            w_dmax_nxt  = w_dmax_in;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                w_out_nxt[i] = (delay_i[i*CNT_W +: CNT_W] == '0) ? level_i[i] : init_i[i];
            end
            if (w_dmax_in == '0) begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = RUN;
                w_busy_nxt  = 1'b1;
            end
        end else if (r_state == RUN) begin
            w_cnt_nxt = w_cnt_inc;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (w_cnt_inc == r_delay[i*CNT_W +: CNT_W]) begin
                    w_out_nxt[i] = r_level[i];
                end
            end
            // Counter is cleared on completion so it never exceeds Dmax-1.
            if (w_cnt_inc == r_dmax) begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_cnt_nxt   = '0;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_delay <= '0;
            r_level <= '0;
            r_dmax  <= '0;
            r_out   <= OUT_RST;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_delay <= w_delay_nxt;
            r_level <= w_level_nxt;
            r_dmax  <= w_dmax_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign out_o  = r_out;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule

// File: doc/multi_delay_gen.md
# multi_delay_gen

Synthesizable, parametrised, multi-channel programmable delay generator. On a single start pulse, each channel drives its programmed initial level, then switches to its programmed final level after a per-channel delay counted in clock cycles. All channels share one counter, and a completion pulse is issued when the longest delay expires. The block sits beside the stimulus/test logic and replaces simulation-only `#delay` assignments with cycle-accurate hardware timing.

## Interface
Parameters:
- `CHANNELS`, 4, number of independent delayed outputs (1..32)
- `CNT_W`, 16, delay counter width; maximum delay 2^CNT_W-1 cycles
- `OUT_RST`, {CHANNELS{1'b0}}, value of `out_o` during and after reset

Ports:
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `start_i` in 1: start request, sampled each rising edge
- `delay_i` in CHANNELS*CNT_W: per-channel delay; channel i uses bits [i*CNT_W +: CNT_W]; sampled only on the accepted start edge
- `init_i` in CHANNELS: per-channel level driven from the start edge until the channel fires
- `level_i` in CHANNELS: per-channel level driven once the channel fires
- `out_o` out CHANNELS: delayed outputs (registered)
- `busy_o` out 1: high while a sequence is running
- `done_o` out 1: one-cycle pulse when the sequence completes

## Operation
- States: IDLE, RUN.
- Reset (`rst_n`=0 at an edge) gives: state IDLE, `out_o`=OUT_RST, `busy_o`=0, `done_o`=0, counter=0, latched delays=0. Reset applied mid-RUN aborts the sequence immediately and no `done_o` is issued.
- IDLE, `start_i`=1 at edge T (the accept edge):
  - Latch `delay_i`, `init_i` and `level_i`.
  - Counter loads 0.
  - Dmax = maximum latched delay.
  - For each channel, `out_o[i]` <= `level_i[i]` if D_i=0, else `init_i[i]`.
  - If Dmax=0: stay IDLE; `done_o`=1 for one cycle; `busy_o` stays 0.
  - Otherwise go to RUN; `busy_o`=1.
- RUN, each edge:
  - Counter increments by 1.
  - Any channel with counter+1 == D_i loads its latched level.
  - Outputs that have already fired hold their value.
  - Unfired outputs hold their init value.
- RUN at edge T+Dmax (counter+1 == Dmax): final channel(s) fire, state goes to IDLE, `busy_o` <= 0, `done_o` <= 1 for exactly one cycle.
- IDLE without start: `out_o` holds its last value. It does not return to OUT_RST.
- Equal delays on several channels fire on the same edge.
- Counter arithmetic is unsigned, CNT_W bits. The counter never exceeds Dmax-1, so it cannot wrap.
- Changes on `delay_i`, `init_i` or `level_i` after the accept edge have no effect on the running sequence.

## Timing
- Channel with D_i ≥ 1: `out_o[i]` = init from edge T, = level from edge T+D_i. This gives exactly D_i cycles of init.
- Channel with D_i = 0: `out_o[i]` = level from edge T.
- `busy_o` is high from edge T to edge T+Dmax, i.e. Dmax cycles.
- `done_o` is high for the single cycle following edge T+Dmax, or following edge T when Dmax=0.
- Earliest next accept edge: T+Dmax+1, which is back-to-back with `done_o` high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `DELAY_GEN_RETRIGGER_EN` defined:
  - `start_i`=1 in RUN restarts the sequence exactly as an IDLE accept: re-latch inputs, counter=0, outputs re-initialised, Dmax recomputed.
  - Restart takes priority over completion on the same edge; that edge produces no `done_o` pulse.
- `DELAY_GEN_RETRIGGER_EN` not defined:
  - `start_i` is ignored while in RUN, including on the completion edge T+Dmax.
  - The sequence always runs to completion.

## Test plan
- Reset and idle:
  - Stimulus: hold `rst_n`=0 for 3 cycles with OUT_RST=4'b1010 and `start_i` toggling.
  - Required: `out_o`=4'b1010, `busy_o`=0, `done_o`=0 throughout reset.
- Basic sequence:
  - Stimulus: CHANNELS=4, delays {ch3..ch0}={5,0,3,3}, init=0000, level=1111, start at edge T.
  - Required: `out_o`=0100 after edge T, 0111 after edge T+3, 1111 after edge T+5; `busy_o`=1 for 5 cycles; a single `done_o` pulse after edge T+5.
- All-zero delays:
  - Stimulus: all delays 0, level=1001.
  - Required: `out_o`=1001 after edge T, `done_o` pulses one cycle after edge T, `busy_o` never asserts.
- Maximum delay:
  - Stimulus: CNT_W=4, D=15 on channel 0.
  - Required: output switches exactly at edge T+15, no counter wrap, `done_o` pulses once.
- Start while busy:
  - Stimulus: second start at edge T+2 of a Dmax=5 run.
  - Required with macro: sequence restarts, fires at T+2+D_i, and only one `done_o` pulse occurs.
  - Required without macro: start ignored, original `done_o` after edge T+5.
- Reset mid-run:
  - Stimulus: `rst_n`=0 at edge T+2.
  - Required: `out_o`=OUT_RST, state IDLE, no `done_o` pulse.
